// File: rtl/trace_pkt_sink.sv
// trace_pkt_sink: receive endpoint for the 3-slot instruction-trace packet.
// It compacts the valid slots into a FIFO of one record per entry and
// presents them one per cycle under valid/ready. A packet that does not
// fit is dropped whole, and the drop is counted.
module trace_pkt_sink #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic [2:0]                 trace_rv_i_valid_ip,
    input  logic [95:0]                trace_rv_i_insn_ip,
    input  logic [95:0]                trace_rv_i_address_ip,
    input  logic [2:0]                 trace_rv_i_exception_ip,
    input  logic [4:0]                 trace_rv_i_ecause_ip,
    input  logic [2:0]                 trace_rv_i_interrupt_ip,
    input  logic [31:0]                trace_rv_i_tval_ip,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_insn,
    output logic [31:0]                out_addr,
    output logic                       out_exception,
    output logic                       out_interrupt,
    output logic [4:0]                 out_ecause,
    output logic [31:0]                out_tval,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt,
    input  logic                       clear_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exception;
        logic        interrupt;
        logic [4:0]  ecause;
        logic [31:0] tval;
    } rec_t;

    rec_t             mem [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [1:0]       n;
    logic [CW-1:0]    free_sp;
    logic             push, drop, pop;
    logic [AW-1:0]    widx [3];
    rec_t             rec [3];
    rec_t             head;

    // Push/drop decision, compacted write addresses and next-state values
    always_comb begin
        n       = {1'b0, trace_rv_i_valid_ip[0]} + {1'b0, trace_rv_i_valid_ip[1]}
                + {1'b0, trace_rv_i_valid_ip[2]};
        free_sp = CW'(DEPTH) - count_q;
        push    = (n != 2'd0) && (CW'(n) <= free_sp);
        drop    = (n != 2'd0) && !(CW'(n) <= free_sp);
        pop     = (count_q != '0) && out_ready;

        // each slot lands after the valid slots below it, so gaps are skipped
        widx[0] = wr_q;
        widx[1] = wr_q + AW'(trace_rv_i_valid_ip[0]);
        widx[2] = wr_q + AW'(trace_rv_i_valid_ip[0]) + AW'(trace_rv_i_valid_ip[1]);

        for (int unsigned i = 0; i < 3; i++) begin
            rec[i].insn      = trace_rv_i_insn_ip[32*i +: 32];
            rec[i].addr      = trace_rv_i_address_ip[32*i +: 32];
            rec[i].exception = trace_rv_i_exception_ip[i];
            rec[i].interrupt = trace_rv_i_interrupt_ip[i];
            if (trace_rv_i_exception_ip[i] || trace_rv_i_interrupt_ip[i]) begin
                rec[i].ecause = trace_rv_i_ecause_ip;
                rec[i].tval   = trace_rv_i_tval_ip;
            end else begin
                rec[i].ecause = '0;
                rec[i].tval   = '0;
            end
        end

        wr_d    = wr_q + (push ? AW'(n) : '0);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + (push ? CW'(n) : '0) - CW'(pop);

        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow)
                drop_d = CNT_W'(1);
            else if (drop_q != '1)
                drop_d = drop_q + CNT_W'(1);
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
    end

    // Pointer, occupancy and drop-status registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Record storage; contents are never reset and are masked at the output
    always_ff @(posedge clk) begin
        if (push) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (trace_rv_i_valid_ip[i])
                    mem[widx[i]] <= rec[i];
            end
        end
    end

    // Head record, forced to zero while the FIFO is empty
    always_comb begin
        head          = mem[rd_q];
        out_valid     = (count_q != '0);
        out_insn      = out_valid ? head.insn      : '0;
        out_addr      = out_valid ? head.addr      : '0;
        out_exception = out_valid ? head.exception : 1'b0;
        out_interrupt = out_valid ? head.interrupt : 1'b0;
        out_ecause    = out_valid ? head.ecause    : '0;
        out_tval      = out_valid ? head.tval      : '0;
        fifo_count    = count_q;
        overflow      = overflow_q;
        drop_cnt      = drop_q;
    end

endmodule
